// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
//
// Line-buffer front end for the Sobel stage.
//
// A raster-order pixel stream enters over a valid/ready handshake. The two
// previous rows are kept in two synchronous 1R1W line RAMs (COLS_P deep,
// WIDTH_P wide, one-cycle read latency). For every accepted pixel at
// row >= 2 and col >= 2, one 3x3 window centred on (row-1, col-1) is
// emitted, two cycles after that pixel is accepted when not stalled.
//
// Ports:
//   clk_i       in   1          clock, rising edge
//   reset_i     in   1          synchronous active-high reset
//   valid_i     in   1          input pixel valid
//   pixel_i     in   WIDTH_P    input pixel, raster order
//   ready_o     out  1          block accepts a pixel this cycle
//   valid_o     out  1          window_o holds a valid window
//   window_o    out  9*WIDTH_P  element k = 3*r+j at [k*WIDTH_P +: WIDTH_P]
//                               (r=0 top row, j=0 leftmost, k=8 newest)
//   last_o      out  1          final window of a frame (qualifies valid_o)
//   ready_i     in   1          downstream accepts window this cycle
//   stall_cnt_o out  32         only with SOBEL_WIN_STALL_CNT_EN defined:
//                               saturating count of valid_o & ~ready_i
//
// Optional feature macro: SOBEL_WIN_STALL_CNT_EN
// ---------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int WIDTH_P = 8,
    parameter int COLS_P  = 640,
    parameter int ROWS_P  = 480
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [WIDTH_P-1:0]   pixel_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [9*WIDTH_P-1:0] window_o,
    output logic                 last_o,
    input  logic                 ready_i
`ifdef SOBEL_WIN_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int CW = $clog2(COLS_P);
    localparam int RW = $clog2(ROWS_P);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_P - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Position of the next pixel to be accepted
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;

    // Stage 1: accepted pixel waiting for its line-buffer read data
    logic               s1_valid_r;
    logic               s1_win_r;
    logic               s1_last_r;
    logic [WIDTH_P-1:0] s1_pix_r;
    logic [CW-1:0]      s1_col_r;

    // Line RAMs and their registered read data
    logic [WIDTH_P-1:0] line0_mem [COLS_P];
    logic [WIDTH_P-1:0] line1_mem [COLS_P];
    logic [WIDTH_P-1:0] rd0_r;
    logic [WIDTH_P-1:0] rd1_r;

    // Two previous columns of the window, per row (0 = older)
    logic [WIDTH_P-1:0] top0_r, top1_r, mid0_r, mid1_r, bot0_r, bot1_r;

    // Output register
    logic                 out_valid_r;
    logic                 out_last_r;
    logic [9*WIDTH_P-1:0] out_win_r;

    logic                 out_free_s;
    logic                 s1_win_live_s;
    logic                 s1_go_s;
    logic                 s1_fire_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 win_en_s;
    logic                 last_pix_s;
    logic [9*WIDTH_P-1:0] win_s;

    // Handshake and flow control. A stage-1 pixel that carries no window
    // never needs the output register, so only window-carrying pixels stall.
    always_comb begin
        out_free_s    = ~out_valid_r | ready_i;
        s1_win_live_s = s1_valid_r & s1_win_r;
        s1_go_s       = ~s1_win_live_s | out_free_s;
        s1_fire_s     = s1_valid_r & s1_go_s;
        ready_s       = ~reset_i & (~s1_valid_r | s1_go_s);
        accept_s      = valid_i & ready_s;
        win_en_s      = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
        last_pix_s    = (row_r == ROW_LAST) && (col_r == COL_LAST);
        // Element 8 (MSB) is the newest pixel, element 0 the oldest top-left
        win_s = {s1_pix_r, bot1_r, bot0_r,
                 rd0_r,    mid1_r, mid0_r,
                 rd1_r,    top1_r, top0_r};
    end

    // Raster position counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Stage-1 register: loaded on accept, emptied when it fires
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_r <= 1'b0;
            s1_win_r   <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_pix_r   <= '0;
            s1_col_r   <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_win_r   <= win_en_s;
            s1_last_r  <= last_pix_s;
            s1_pix_r   <= pixel_i;
            s1_col_r   <= col_r;
        end else if (s1_fire_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Line RAMs: read issued on accept (address held otherwise, so read data
    // survives a stall); the write happens when the pixel leaves stage 1,
    // with line1 taking the old line0 word just read at that column.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            rd0_r <= line0_mem[col_r];
            rd1_r <= line1_mem[col_r];
        end
        if (s1_fire_s) begin
            line0_mem[s1_col_r] <= s1_pix_r;
            line1_mem[s1_col_r] <= rd0_r;
        end
    end

    // Column shift registers feeding the left two window columns
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            top0_r <= '0;
            top1_r <= '0;
            mid0_r <= '0;
            mid1_r <= '0;
            bot0_r <= '0;
            bot1_r <= '0;
        end else if (s1_fire_s) begin
            top0_r <= top1_r;
            top1_r <= rd1_r;
            mid0_r <= mid1_r;
            mid1_r <= rd0_r;
            bot0_r <= bot1_r;
            bot1_r <= s1_pix_r;
        end else begin
            top0_r <= top0_r;
            top1_r <= top1_r;
            mid0_r <= mid0_r;
            mid1_r <= mid1_r;
            bot0_r <= bot0_r;
            bot1_r <= bot1_r;
        end
    end

    // Output register: held while valid and not taken downstream
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_win_r   <= '0;
        end else if (s1_fire_s && s1_win_live_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= s1_last_r;
            out_win_r   <= win_s;
        end else if (ready_i) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

`ifdef SOBEL_WIN_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where a window waits on downstream
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_r <= 32'd0;
        end else if (out_valid_r && !ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

    assign ready_o  = ready_s;
    assign valid_o  = out_valid_r;
    assign last_o   = out_last_r;
    assign window_o = out_win_r;

endmodule
